// File: rtl/em_exc_pipe_reg.sv
// rtl/em_exc_pipe_reg.sv - E->M pipeline register with exception code, bubble and CP0 flush handling
//
// Purpose:
//   Carries the merged E-stage exception code plus PC/BD/instruction and datapath
//   fields into the M stage. A CP0 request flushes M and loads the redirect PC.
//   A held M stage freezes everything. An E stall inserts a bubble that still
//   carries PC/BD, so an interrupt taken on the bubble captures the right EPC/BD.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req, req_pc         CP0 flush request and the PC to load into m_pc on flush
//   e_stall             E stalled: bubble into M
//   m_hold              M frozen: all M registers keep their value
//   e_exc_code ..       E-stage fields (exception code, pc, bd, instr, alu_out,
//   e_mem_we            rt_data, wa, wr_en, mem_we)
//   m_exc_code ..       registered copies of the E fields
//   m_mem_we
//   m_valid             M holds a real instruction
//   m_exc_pend          m_valid and a non-zero m_exc_code
module em_exc_pipe_reg #(
   parameter int unsigned      DW       = 32,
   parameter logic [DW-1:0]    PC_RESET = 32'h0000_3000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [DW-1:0] req_pc,
   input  logic          e_stall,
   input  logic          m_hold,
   input  logic [4:0]    e_exc_code,
   input  logic [DW-1:0] e_pc,
   input  logic          e_bd,
   input  logic [DW-1:0] e_instr,
   input  logic [DW-1:0] e_alu_out,
   input  logic [DW-1:0] e_rt_data,
   input  logic [4:0]    e_wa,
   input  logic          e_wr_en,
   input  logic          e_mem_we,
   output logic [4:0]    m_exc_code,
   output logic [DW-1:0] m_pc,
   output logic          m_bd,
   output logic [DW-1:0] m_instr,
   output logic [DW-1:0] m_alu_out,
   output logic [DW-1:0] m_rt_data,
   output logic [4:0]    m_wa,
   output logic          m_wr_en,
   output logic          m_mem_we,
   output logic          m_valid,
   output logic          m_exc_pend
);

   // A faulting instruction must not write the register file or memory.
   logic eHasExc;
   assign eHasExc = (e_exc_code != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc       <= PC_RESET;
         m_bd       <= 1'b0;
         m_exc_code <= 5'd0;
         m_instr    <= '0;
         m_alu_out  <= '0;
         m_rt_data  <= '0;
         m_wa       <= 5'd0;
         m_wr_en    <= 1'b0;
         m_mem_we   <= 1'b0;
         m_valid    <= 1'b0;
      end else if (req) begin
         // Flush wins over hold and stall: M becomes an empty slot at the redirect PC.
         m_pc       <= req_pc;
         m_bd       <= 1'b0;
         m_exc_code <= 5'd0;
         m_instr    <= '0;
         m_alu_out  <= '0;
         m_rt_data  <= '0;
         m_wa       <= 5'd0;
         m_wr_en    <= 1'b0;
         m_mem_we   <= 1'b0;
         m_valid    <= 1'b0;
      end else if (!m_hold) begin
         // PC/BD advance for bubbles as well as real instructions.
         m_pc <= e_pc;
         m_bd <= e_bd;
         if (e_stall) begin
            m_exc_code <= 5'd0;
            m_instr    <= '0;
            m_alu_out  <= '0;
            m_rt_data  <= '0;
            m_wa       <= 5'd0;
            m_wr_en    <= 1'b0;
            m_mem_we   <= 1'b0;
            m_valid    <= 1'b0;
         end else begin
            m_exc_code <= e_exc_code;
            m_instr    <= e_instr;
            m_alu_out  <= e_alu_out;
            m_rt_data  <= e_rt_data;
            m_wa       <= e_wa;
            m_wr_en    <= e_wr_en  & ~eHasExc;
            m_mem_we   <= e_mem_we & ~eHasExc;
            m_valid    <= 1'b1;
         end
      end
   end

   assign m_exc_pend = m_valid & (m_exc_code != 5'd0);

endmodule
